// File: rtl/arc4_encrypt.sv
// RC4 encryptor: S init, KSA, then PRGA over a length-prefixed pt string into ct.
// Latency 256 + 4*256 + 2 + 6*L + 1 cycles from accepted en; en is ignored while rdy=0.
module arc4_encrypt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [3:0] {
        IDLE, INIT,
        KSA_RI, KSA_RJ, KSA_WI, KSA_WJ,
        LEN_RD, LEN_WR,
        PR_RI, PR_RJ, PR_WI, PR_WJ, PR_RP, PR_WR,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  i, j, k, len;
    logic [7:0]  si, sj, ptb;
    logic [1:0]  kidx;
    logic [23:0] key_r;

    logic [7:0]  key_byte, j_ksa, j_prga, i_inc, pad_idx;

    always_comb begin
        case (kidx)
            2'd0:    key_byte = key_r[23:16];
            2'd1:    key_byte = key_r[15:8];
            default: key_byte = key_r[7:0];
        endcase
    end

    // s_rddata here is S[i] read in the previous cycle
    assign j_ksa   = j + s_rddata + key_byte;
    assign j_prga  = j + s_rddata;
    assign i_inc   = i + 8'd1;
    assign pad_idx = si + sj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        pt_addr   = 8'd0;
        ct_addr   = 8'd0;
        ct_wrdata = 8'd0;
        ct_wren   = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_nxt = INIT;
            end
            INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
                if (i == 8'hFF) state_nxt = KSA_RI;
            end
            KSA_RI: begin
                s_addr    = i;
                state_nxt = KSA_RJ;
            end
            KSA_RJ: begin
                s_addr    = j_ksa;
                state_nxt = KSA_WI;
            end
            KSA_WI: begin
                s_addr    = i;
                s_wrdata  = s_rddata;
                s_wren    = 1'b1;
                state_nxt = KSA_WJ;
            end
            KSA_WJ: begin
                s_addr    = j;
                s_wrdata  = si;
                s_wren    = 1'b1;
                state_nxt = (i == 8'hFF) ? LEN_RD : KSA_RI;
            end
            LEN_RD: begin
                pt_addr   = 8'd0;
                state_nxt = LEN_WR;
            end
            LEN_WR: begin
                ct_addr   = 8'd0;
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
                state_nxt = (pt_rddata == 8'd0) ? DONE : PR_RI;
            end
            PR_RI: begin
                s_addr    = i_inc;
                pt_addr   = k;
                state_nxt = PR_RJ;
            end
            PR_RJ: begin
                s_addr    = j_prga;
                state_nxt = PR_WI;
            end
            PR_WI: begin
                s_addr    = i;
                s_wrdata  = s_rddata;
                s_wren    = 1'b1;
                state_nxt = PR_WJ;
            end
            PR_WJ: begin
                s_addr    = j;
                s_wrdata  = si;
                s_wren    = 1'b1;
                state_nxt = PR_RP;
            end
            PR_RP: begin
                s_addr    = pad_idx;
                state_nxt = PR_WR;
            end
            PR_WR: begin
                ct_addr   = k;
                ct_wrdata = ptb ^ s_rddata;
                ct_wren   = 1'b1;
                state_nxt = (k == len) ? DONE : PR_RI;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            len   <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
            ptb   <= 8'd0;
            kidx  <= 2'd0;
            key_r <= 24'd0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    key_r <= key;
                    i     <= 8'd0;
                end
                INIT: begin
                    i <= i_inc;
                    if (i == 8'hFF) begin
                        j    <= 8'd0;
                        kidx <= 2'd0;
                    end
                end
                KSA_RJ: begin
                    si <= s_rddata;
                    j  <= j_ksa;
                end
                KSA_WJ: begin
                    i    <= i_inc;
                    kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                end
                LEN_WR: begin
                    len <= pt_rddata;
                    i   <= 8'd0;
                    j   <= 8'd0;
                    k   <= 8'd1;
                end
                PR_RI: i <= i_inc;
                PR_RJ: begin
                    si  <= s_rddata;
                    ptb <= pt_rddata;
                    j   <= j_prga;
                end
                PR_WI: sj <= s_rddata;
                PR_WR: k  <= k + 8'd1;
                default: ;
            endcase
        end
    end

endmodule
